// File: rtl/hs_word_packer_pkg.sv
// Shared constants and elaboration helpers for the valid/ready handshake chain.
// Holds the default word width and a ceiling-log2 used to size lane counters.
package hs_word_packer_pkg;

    localparam int DEFAULT_WORD_WIDTH = 10;

    // Smallest r with 2**r >= value, floored at 1 so that a 1-bit counter still exists.
    function automatic int hs_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result == 0) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/hs_word_packer.sv
// Packs PACK_COUNT consecutive input words into one wide word with a per-lane keep
// mask; an input_last beat flushes a partial word early. Output side is fully registered.
module hs_word_packer
    import hs_word_packer_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int PACK_COUNT = 4
) (
    input  logic                             clock,
    input  logic                             clear_n,
    input  logic                             input_valid,
    output logic                             input_ready,
    input  logic [WORD_WIDTH-1:0]            input_data,
    input  logic                             input_last,
    output logic                             output_valid,
    input  logic                             output_ready,
    output logic [WORD_WIDTH*PACK_COUNT-1:0] output_data,
    output logic [PACK_COUNT-1:0]            output_keep,
    output logic                             output_last
);

    localparam int COUNT_WIDTH = hs_clog2(PACK_COUNT);
    localparam logic [COUNT_WIDTH-1:0] LAST_LANE = COUNT_WIDTH'(PACK_COUNT - 1);

    logic [COUNT_WIDTH-1:0]                 cnt_q,       cnt_d;
    logic [PACK_COUNT-1:0][WORD_WIDTH-1:0]  acc_data_q,  acc_data_d;
    logic [PACK_COUNT-1:0]                  acc_keep_q,  acc_keep_d;
    logic                                   out_valid_q, out_valid_d;
    logic [PACK_COUNT-1:0][WORD_WIDTH-1:0]  out_data_q,  out_data_d;
    logic [PACK_COUNT-1:0]                  out_keep_q,  out_keep_d;
    logic                                   out_last_q,  out_last_d;

    logic                                   input_ready_s;
    logic                                   accept_s;
    logic                                   completing_s;
    logic [PACK_COUNT-1:0][WORD_WIDTH-1:0]  merged_data_s;
    logic [PACK_COUNT-1:0]                  merged_keep_s;
    logic [PACK_COUNT-1:0][WORD_WIDTH-1:0]  packed_data_s;

    // Upstream may push whenever the output slot is empty or is being drained this cycle.
    always_comb begin
        input_ready_s = clear_n && (!out_valid_q || output_ready);
        accept_s      = input_valid && input_ready_s;
        completing_s  = accept_s && ((cnt_q == LAST_LANE) || input_last);
    end

    // Accumulator view with the incoming word dropped into lane cnt; stale lanes masked to zero.
    always_comb begin
        merged_data_s = acc_data_q;
        merged_keep_s = acc_keep_q;
        packed_data_s = '0;
        for (int i = 0; i < PACK_COUNT; i++) begin
            merged_data_s[i] = (cnt_q == COUNT_WIDTH'(i)) ? input_data : acc_data_q[i];
            merged_keep_s[i] = (cnt_q == COUNT_WIDTH'(i)) ? 1'b1 : acc_keep_q[i];
        end
        for (int i = 0; i < PACK_COUNT; i++) begin
            packed_data_s[i] = merged_keep_s[i] ? merged_data_s[i] : {WORD_WIDTH{1'b0}};
        end
    end

    // Next-state: a completing beat reloads the output slot, which also covers a same-cycle drain.
    always_comb begin
        cnt_d       = cnt_q;
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (completing_s) begin
            out_data_d  = packed_data_s;
            out_keep_d  = merged_keep_s;
            out_last_d  = input_last;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            acc_keep_d  = '0;
        end else if (accept_s) begin
            acc_data_d  = merged_data_s;
            acc_keep_d  = merged_keep_s;
            cnt_d       = cnt_q + COUNT_WIDTH'(1);
            if (out_valid_q && output_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else if (out_valid_q && output_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset drops any partial accumulation and any held output word.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q       <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign input_ready  = input_ready_s;
    assign output_valid = out_valid_q;
    assign output_data  = out_data_q;
    assign output_keep  = out_keep_q;
    assign output_last  = out_last_q;

endmodule

// File: tb/tb_hs_word_packer.sv
// Directed bench for hs_word_packer (WORD_WIDTH=10, PACK_COUNT=4): a per-cycle vector
// table for packing/flush/streaming plus hand sequences for reset and backpressure.
module tb_hs_word_packer;

    localparam int WW = 10;
    localparam int PC = 4;
    localparam int OW = WW * PC;
    localparam int NV = 19;

    logic          clock = 1'b0;
    logic          clear_n;
    logic          input_valid;
    logic          input_ready;
    logic [WW-1:0] input_data;
    logic          input_last;
    logic          output_valid;
    logic          output_ready;
    logic [OW-1:0] output_data;
    logic [PC-1:0] output_keep;
    logic          output_last;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          v;
        logic [WW-1:0] d;
        logic          l;
        logic          ordy;
        logic          e_rdy;
        logic          e_ov;
        logic [OW-1:0] e_data;
        logic [PC-1:0] e_keep;
        logic          e_last;
    } vec_t;

    vec_t vecs [NV];

    hs_word_packer #(.WORD_WIDTH(WW), .PACK_COUNT(PC)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .input_last   (input_last),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_keep  (output_keep),
        .output_last  (output_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] pk(input logic [WW-1:0] l3, input logic [WW-1:0] l2,
                                         input logic [WW-1:0] l1, input logic [WW-1:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic vec_t mk(input logic v, input logic [WW-1:0] d, input logic l,
                                input logic e_ov, input logic [OW-1:0] e_data,
                                input logic [PC-1:0] e_keep, input logic e_last);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.ordy = 1'b1; r.e_rdy = 1'b1;
        r.e_ov = e_ov; r.e_data = e_data; r.e_keep = e_keep; r.e_last = e_last;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Full pack of 1..4
        vecs[0]  = mk(1'b1, 10'h001, 1'b0, 1'b0, '0, 4'b0000, 1'b0);
        vecs[1]  = mk(1'b1, 10'h002, 1'b0, 1'b0, '0, 4'b0000, 1'b0);
        vecs[2]  = mk(1'b1, 10'h003, 1'b0, 1'b0, '0, 4'b0000, 1'b0);
        vecs[3]  = mk(1'b1, 10'h004, 1'b0, 1'b1, pk(10'h004, 10'h003, 10'h002, 10'h001), 4'b1111, 1'b0);
        // Flush of a two-word packet, then a lane-0 last beat completing while the previous word drains
        vecs[4]  = mk(1'b1, 10'h0AA, 1'b0, 1'b0, '0, 4'b0000, 1'b0);
        vecs[5]  = mk(1'b1, 10'h0BB, 1'b1, 1'b1, pk(10'h000, 10'h000, 10'h0BB, 10'h0AA), 4'b0011, 1'b1);
        vecs[6]  = mk(1'b1, 10'h155, 1'b1, 1'b1, pk(10'h000, 10'h000, 10'h000, 10'h155), 4'b0001, 1'b1);
        // Streaming 1..12, input_ready stays high throughout
        for (int i = 0; i < 12; i++) begin
            if ((i % 4) == 3) begin
                vecs[7 + i] = mk(1'b1, 10'(i + 1), 1'b0, 1'b1,
                                 pk(10'(i + 1), 10'(i), 10'(i - 1), 10'(i - 2)), 4'b1111, 1'b0);
            end else begin
                vecs[7 + i] = mk(1'b1, 10'(i + 1), 1'b0, 1'b0, '0, 4'b0000, 1'b0);
            end
        end

        // Reset held with input_valid high
        clear_n      = 1'b0;
        input_valid  = 1'b1;
        input_data   = 10'h3FF;
        input_last   = 1'b1;
        output_ready = 1'b1;
        repeat (3) tick();
        check("rst_ready", 64'(input_ready), 64'd0);
        check("rst_ovalid", 64'(output_valid), 64'd0);
        check("rst_keep", 64'(output_keep), 64'd0);
        check("rst_data", 64'(output_data), 64'd0);
        check("rst_last", 64'(output_last), 64'd0);
        input_valid = 1'b0;
        input_last  = 1'b0;
        clear_n     = 1'b1;
        tick();
        check("rel_ready", 64'(input_ready), 64'd1);
        check("rel_ovalid", 64'(output_valid), 64'd0);

        for (int k = 0; k < NV; k++) begin
            input_valid  = vecs[k].v;
            input_data   = vecs[k].d;
            input_last   = vecs[k].l;
            output_ready = vecs[k].ordy;
            #1;
            check($sformatf("v%0d_ready", k), 64'(input_ready), 64'(vecs[k].e_rdy));
            tick();
            check($sformatf("v%0d_ovalid", k), 64'(output_valid), 64'(vecs[k].e_ov));
            if (vecs[k].e_ov) begin
                check($sformatf("v%0d_data", k), 64'(output_data), 64'(vecs[k].e_data));
                check($sformatf("v%0d_keep", k), 64'(output_keep), 64'(vecs[k].e_keep));
                check($sformatf("v%0d_last", k), 64'(output_last), 64'(vecs[k].e_last));
            end
        end

        // Backpressure on the word {12,11,10,9}: inputs stall, output holds
        input_valid  = 1'b1;
        input_data   = 10'h3FF;
        input_last   = 1'b1;
        output_ready = 1'b0;
        #1;
        check("bp_ready0", 64'(input_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp%0d_ovalid", c), 64'(output_valid), 64'd1);
            check($sformatf("bp%0d_data", c), 64'(output_data),
                  64'(pk(10'd12, 10'd11, 10'd10, 10'd9)));
            check($sformatf("bp%0d_keep", c), 64'(output_keep), 64'hF);
            check($sformatf("bp%0d_last", c), 64'(output_last), 64'd0);
            check($sformatf("bp%0d_ready", c), 64'(input_ready), 64'd0);
        end
        input_valid  = 1'b0;
        input_last   = 1'b0;
        output_ready = 1'b1;
        #1;
        check("bp_ready_release", 64'(input_ready), 64'd1);
        tick();
        check("bp_drained", 64'(output_valid), 64'd0);

        // Mid-operation reset after two accepted words
        input_valid = 1'b1;
        input_data  = 10'h011;
        tick();
        input_data  = 10'h022;
        tick();
        input_valid = 1'b0;
        clear_n     = 1'b0;
        #2;
        check("mrst_ready", 64'(input_ready), 64'd0);
        check("mrst_ovalid", 64'(output_valid), 64'd0);
        clear_n = 1'b1;
        tick();
        check("mrst_no_emit", 64'(output_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            input_valid = 1'b1;
            input_data  = 10'(10'h031 + i);
            tick();
            check($sformatf("mrst_w%0d_ovalid", i), 64'(output_valid), 64'(i == 3));
        end
        input_valid = 1'b0;
        check("mrst_data", 64'(output_data), 64'(pk(10'h034, 10'h033, 10'h032, 10'h031)));
        check("mrst_keep", 64'(output_keep), 64'hF);
        check("mrst_last", 64'(output_last), 64'd0);
        tick();
        check("mrst_drained", 64'(output_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
